kbest_layer_scheduler: RTL and testbench
========================================

Name: kbest_layer_scheduler

Overview:
- Sequences one 4x4 K-best detection job through the layer datapath.
- Latches the upper-triangular R and rotated Y of a job, then issues layers 3, 2, 1 and 0 in order. Layer 3 goes to the path generator; layers 2, 1 and 0 go to the path finders with N=2, 3 and 4.
- Presents the correct R row slice and Y element for each layer, and pulses a per-layer issue strobe.
- Returns job completion to the downstream slicer through a valid/ready handshake.

Parameters:
- WL, 16, fixed-point word length of R and Y elements.
- GEN_LAT, 1, cycles from a layer-3 issue until its survivors are valid at the next stage (legal range 1..15).
- STAGE_LAT, 2, cycles from a path-finder layer issue until its sorted survivors are valid (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  job offered
- in_ready  out  1  scheduler can accept a job
- R_in  in  10*WL  R elements r00,r01,r02,r03,r11,r12,r13,r22,r23,r33 in slots 0..9, slot 0 at LSBs
- Y_in  in  4*WL  y0..y3, y0 at LSBs
- flush  in  1  abort the current job
- layer_sel  out  2  layer being issued (3..0)
- lay_issue  out  1  one-cycle issue strobe
- R_row  out  4*WL  row slice for the issued layer, pivot in slot 0, zero-padded
- Y_cur  out  WL  y element for the issued layer
- out_valid  out  1  final survivors valid
- out_ready  in  1  downstream accepts the result
- busy  out  1  job in flight (state is not IDLE)
- job_cnt  out  8  completed-job counter

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge), whether idle or mid-job:
  - state becomes IDLE.
  - in_ready=1.
  - lay_issue=0, out_valid=0, busy=0.
  - layer_sel=0, R_row=0, Y_cur=0.
  - job_cnt=0.
  - Latched R/Y are cleared to 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch R_in/Y_in, set layer=3, go to ISSUE.
- ISSUE (exactly one cycle):
  - lay_issue=1 with layer_sel=layer.
  - R_row/Y_cur driven from the latched data per the mapping below.
  - Load wait counter with (layer==3 ? GEN_LAT : STAGE_LAT) - 1, go to WAIT.
- WAIT:
  - lay_issue=0; R_row, Y_cur and layer_sel hold their last values.
  - Decrement the counter. At a count of 0: if layer==0 go to DONE, else decrement layer and go to ISSUE.
- DONE:
  - out_valid=1, held until out_ready=1.
  - On that handshake edge: job_cnt increments (wraps 255 to 0), go to IDLE.
  - in_ready rises the cycle after the handshake.
  - out_valid is never dropped without out_ready.
- Row mapping:
  - Layer 3: R_row = {0, 0, 0, r33}; Y_cur = y3.
  - Layer 2: R_row = {0, 0, r23, r22}; Y_cur = y2.
  - Layer 1: R_row = {0, r13, r12, r11}; Y_cur = y1.
  - Layer 0: R_row = {r03, r02, r01, r00}; Y_cur = y0.
  - R_row slot i occupies bits [(i+1)*WL-1 : i*WL].
  - Slots above N are zero.
- Timing, for accept edge at cycle a:
  - Layer 3 issues at a+1.
  - Layer 2 issues at a+1+GEN_LAT.
  - Layer 1 issues STAGE_LAT cycles after layer 2; layer 0 issues STAGE_LAT cycles after layer 1.
  - out_valid rises at (layer-0 issue)+STAGE_LAT.
  - With defaults, issues are at a+1, a+2, a+4, a+6 and out_valid at a+8.
- Flush:
  - In ISSUE, WAIT or DONE: next state is IDLE, lay_issue=0, out_valid=0, job_cnt unchanged.
  - In IDLE, flush blocks acceptance that cycle even if in_valid=1.
  - Flush and out_ready together in DONE: flush wins and no count is recorded.
- rst has priority over flush.
- Out-of-range GEN_LAT or STAGE_LAT is a configuration error; simulation asserts.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> in_ready=1, busy=0, job_cnt=0, out_valid=0.
- Single job with defaults, r33=16'h0400, y3=16'h0100, all other slots distinct, out_ready=1:
  - lay_issue pulses at a+1, a+2, a+4, a+6 with layer_sel 3, 2, 1, 0.
  - R_row at layer 2 = {0, 0, r23, r22}.
  - out_valid=1 at a+8 for one cycle; job_cnt becomes 1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid stays 1, in_ready stays 0; on release, job_cnt increments once.
- Flush at a+3 (during layer-2 WAIT) -> no further lay_issue, out_valid never asserts, in_ready=1 at a+4, job_cnt unchanged.
- Reset mid-job: rst=1 at a+5 -> all outputs zero at the next edge; a new job accepted afterwards issues layer 3 first.
- Parameter sweep GEN_LAT=3, STAGE_LAT=4 -> issues at a+1, a+4, a+8, a+12 and out_valid at a+16. Back-to-back jobs with in_valid held high: 256 jobs make job_cnt wrap to 0.

Source files
------------

// File: rtl/kbest_layer_scheduler.sv
// kbest_layer_scheduler: sequences one 4x4 K-best job through layers 3..0 and hands the result downstream
module kbest_layer_scheduler #(
  parameter int WL = 16,
  parameter int GEN_LAT = 1,
  parameter int STAGE_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [10*WL-1:0] R_in,
  input  logic [4*WL-1:0] Y_in,
  input  logic            flush,
  output logic [1:0]      layer_sel,
  output logic            lay_issue,
  output logic [4*WL-1:0] R_row,
  output logic [WL-1:0]   Y_cur,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [7:0]      job_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [9:0][WL-1:0] r_q;
  logic [3:0][WL-1:0] y_q;
  logic [1:0] layer;
  logic [3:0] cnt;
  logic [3:0] lat;
  logic [4*WL-1:0] row;
  // latency of the current layer and its zero-padded row slice, pivot in slot 0
  always_comb begin
    lat = layer == 2'd3 ? 4'(GEN_LAT) : 4'(STAGE_LAT);
    row = layer == 2'd3 ? {{(3*WL){1'b0}}, r_q[9]} :
          layer == 2'd2 ? {{(2*WL){1'b0}}, r_q[8], r_q[7]} :
          layer == 2'd1 ? {{WL{1'b0}}, r_q[6], r_q[5], r_q[4]} :
                          {r_q[3], r_q[2], r_q[1], r_q[0]};
  end
  // job FSM; ISSUE drives the strobe on its exit edge, so a latency-1 layer chains straight into the next ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      lay_issue <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      layer_sel <= '0;
      R_row <= '0;
      Y_cur <= '0;
      job_cnt <= '0;
      r_q <= '0;
      y_q <= '0;
      layer <= '0;
      cnt <= '0;
    end else if (flush) begin
      state <= IDLE;
      in_ready <= 1'b1;
      lay_issue <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          r_q <= R_in;
          y_q <= Y_in;
          layer <= 2'd3;
          in_ready <= 1'b0;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          lay_issue <= 1'b1;
          layer_sel <= layer;
          R_row <= row;
          Y_cur <= y_q[layer];
          cnt <= lat - 4'd2;
          state <= lat != 4'd1 ? WAIT : layer == 2'd0 ? DONE : ISSUE;
          if (lat == 4'd1) layer <= layer - 2'd1;
        end
        WAIT: begin
          lay_issue <= 1'b0;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            state <= layer == 2'd0 ? DONE : ISSUE;
            layer <= layer - 2'd1;
          end
        end
        default: begin
          lay_issue <= 1'b0;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            job_cnt <= job_cnt + 8'd1;
            in_ready <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else out_valid <= 1'b1;
        end
      endcase
    end
  end
  // latencies outside 1..15 cannot be counted by the 4-bit wait counter
  always_ff @(posedge clk) begin
    assert (GEN_LAT >= 1 && GEN_LAT <= 15 && STAGE_LAT >= 1 && STAGE_LAT <= 15);
  end
endmodule

// File: tb/tb_kbest_layer_scheduler.sv
// tb_kbest_layer_scheduler: randomized directed bench against a schedule/matrix reference model
module tb_kbest_layer_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [159:0] R_in = '0;
  logic [63:0] Y_in = '0;
  logic in_valid [2] = '{1'b0, 1'b0};
  logic flush [2] = '{1'b0, 1'b0};
  logic out_ready [2] = '{1'b0, 1'b0};
  logic in_ready [2];
  logic lay_issue [2];
  logic out_valid [2];
  logic busy [2];
  logic [1:0] layer_sel [2];
  logic [63:0] r_row [2];
  logic [15:0] y_cur [2];
  logic [7:0] job_cnt [2];
  int checks = 0;
  int errors = 0;
  int cnt [2] = '{0, 0};
  int last_layer [2] = '{0, 0};
  logic [63:0] last_row [2] = '{64'd0, 64'd0};
  logic [15:0] last_y [2] = '{16'd0, 16'd0};

  always #5 clk = ~clk;

  kbest_layer_scheduler u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .R_in(R_in), .Y_in(Y_in),
    .flush(flush[0]), .layer_sel(layer_sel[0]), .lay_issue(lay_issue[0]), .R_row(r_row[0]), .Y_cur(y_cur[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0]), .job_cnt(job_cnt[0]));

  kbest_layer_scheduler #(.GEN_LAT(3), .STAGE_LAT(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .R_in(R_in), .Y_in(Y_in),
    .flush(flush[1]), .layer_sel(layer_sel[1]), .lay_issue(lay_issue[1]), .R_row(r_row[1]), .Y_cur(y_cur[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1]), .job_cnt(job_cnt[1]));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input int d, input int jc);
    chk("idle_in_ready", in_ready[d], 1);
    chk("idle_busy", busy[d], 0);
    chk("idle_out_valid", out_valid[d], 0);
    chk("idle_lay_issue", lay_issue[d], 0);
    chk("idle_job_cnt", job_cnt[d], jc);
  endtask

  // one job: accept, then compare every cycle to the schedule derived from the latencies
  task automatic run_job(input int d, input int stall, input int flush_at, input bit fixed);
    int g, s, tv, h, end_rel, slot, lay;
    int ti [4];
    logic [15:0] rm [4][4];
    logic [15:0] yv [4];
    logic [63:0] row;
    bit fl, hs;
    g = d ? 3 : 1;
    s = d ? 4 : 2;
    ti[3] = 1;
    ti[2] = 1 + g;
    ti[1] = ti[2] + s;
    ti[0] = ti[1] + s;
    tv = ti[0] + s;
    h = tv + 1 + stall;
    end_rel = flush_at > 0 ? flush_at + 1 : h;
    for (int i = 0; i < 4; i++) begin
      yv[i] = 16'($urandom);
      for (int j = 0; j < 4; j++) rm[i][j] = {4'(i), 4'(j), 8'($urandom)};
    end
    if (fixed) begin
      rm[3][3] = 16'h0400;
      yv[3] = 16'h0100;
    end
    slot = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i; j < 4; j++) begin
        R_in[slot*16 +: 16] = rm[i][j];
        slot++;
      end
    for (int i = 0; i < 4; i++) Y_in[i*16 +: 16] = yv[i];
    chk("pre_in_ready", in_ready[d], 1);
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b0;
    step;
    in_valid[d] = 1'b0;
    chk("acc_in_ready", in_ready[d], 0);
    chk("acc_busy", busy[d], 1);
    chk("acc_lay_issue", lay_issue[d], 0);
    for (int rel = 1; rel <= end_rel; rel++) begin
      flush[d] = flush_at > 0 && rel == flush_at + 1;
      out_ready[d] = rel > tv + stall;
      step;
      fl = flush_at > 0 && rel == end_rel;
      hs = !fl && rel == h;
      lay = -1;
      for (int l = 0; l < 4; l++) if (ti[l] == rel && !fl) lay = l;
      if (lay >= 0) begin
        row = '0;
        for (int k = 0; k < 4 - lay; k++) row[k*16 +: 16] = rm[lay][lay+k];
        last_layer[d] = lay;
        last_row[d] = row;
        last_y[d] = yv[lay];
      end
      if (hs) cnt[d] = (cnt[d] + 1) % 256;
      chk("lay_issue", lay_issue[d], lay >= 0);
      chk("layer_sel", layer_sel[d], last_layer[d]);
      chk("r_row", r_row[d], last_row[d]);
      chk("y_cur", y_cur[d], last_y[d]);
      chk("out_valid", out_valid[d], !fl && rel >= tv && rel < h);
      chk("in_ready", in_ready[d], fl || rel >= h);
      chk("busy", busy[d], !(fl || rel >= h));
      chk("job_cnt", job_cnt[d], cnt[d]);
    end
    flush[d] = 1'b0;
    out_ready[d] = 1'b0;
  endtask

  initial begin
    int n;
    bit pend;
    step;
    step;
    rst = 1'b0;
    step;
    chk_idle_zero(0, 0);
    chk_idle_zero(1, 0);
    chk("rst_r_row", r_row[0], 0);
    run_job(0, 0, 0, 1'b1);
    run_job(0, 5, 0, 1'b0);
    run_job(0, 0, 3, 1'b0);
    run_job(0, 0, 8, 1'b0);
    in_valid[0] = 1'b1;
    flush[0] = 1'b1;
    step;
    chk("idle_flush_in_ready", in_ready[0], 1);
    chk("idle_flush_busy", busy[0], 0);
    in_valid[0] = 1'b0;
    flush[0] = 1'b0;
    step;
    chk("idle_flush_no_accept", busy[0], 0);
    in_valid[0] = 1'b1;
    step;
    in_valid[0] = 1'b0;
    repeat (4) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk_idle_zero(0, 0);
    chk("midrst_layer_sel", layer_sel[0], 0);
    chk("midrst_r_row", r_row[0], 0);
    chk("midrst_y_cur", y_cur[0], 0);
    cnt[0] = 0;
    last_layer[0] = 0;
    last_row[0] = '0;
    last_y[0] = '0;
    run_job(0, 0, 0, 1'b0);
    run_job(1, 0, 0, 1'b0);
    run_job(1, 2, 0, 1'b0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    cnt[0] = 0;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    n = 0;
    pend = 1'b0;
    for (int c = 0; c < 4000 && n < 256; c++) begin
      step;
      if (pend) begin
        n++;
        cnt[0] = n % 256;
        chk("wrap_cnt", job_cnt[0], cnt[0]);
        pend = 1'b0;
      end
      if (out_valid[0]) begin
        pend = 1'b1;
        if (n == 255) in_valid[0] = 1'b0;
      end
    end
    chk("wrap_jobs", n, 256);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    step;
    chk("wrap_final", job_cnt[0], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
